// File: rtl/dfb_pkg.sv
// Shared definitions for the $00F1xxxx register window responder.
package dfb_pkg;

    // Register index, taken from A[3:1]
    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_STATUS  = 3'd1;
    localparam logic [2:0] REG_SCRATCH = 3'd2;
    localparam logic [2:0] REG_REV     = 3'd3;
    localparam logic [2:0] REG_KEY     = 3'd4;
    localparam logic [2:0] REG_TICK_LO = 3'd5;
    localparam logic [2:0] REG_TICK_HI = 3'd6;
    localparam logic [2:0] REG_KERRCLR = 3'd7;

    // CTRL bit positions
    localparam int CTRL_FAST_EN    = 0;
    localparam int CTRL_ALTRAM_EN  = 1;
    localparam int CTRL_FLASH_EN   = 2;
    localparam int CTRL_BOOST_LOCK = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_HOLD = 2'd3
    } dfb_state_t;

endpackage

// File: rtl/dfb_sync2.sv
// Two-flop synchroniser for active-low bus strobes; idles high out of reset.
module dfb_sync2 (
    input  logic CLKOSC,
    input  logic RST,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous strobe
    always_ff @(posedge CLKOSC or negedge RST) begin
        if (!RST) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dfb_reg_port.sv
// Register window responder: 16-bit port, acknowledges on DSACK[1] only.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a synchronised AS with a matching A[31:16]
// WAIT  | counting wait states; abandons the cycle if AS rises
// ACK   | one cycle after the acknowledge/data/commit edge
// HOLD  | holding DSACK/DOE until AS rises, released on that edge
module dfb_reg_port
    import dfb_pkg::*;
#(
    parameter logic [15:0] BASE        = 16'h00F1,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [7:0]  REVISION    = 8'h15,
    parameter logic [7:0]  UNLOCK_KEY  = 8'hA5
) (
    input  logic        CLKOSC,
    input  logic        RST,
    input  logic [31:0] A,
    input  logic        AS,
    input  logic        DS,
    input  logic        XRW,
    input  logic [7:0]  DIN,
    input  logic [7:0]  STAT_IN,
    output logic [7:0]  DOUT,
    output logic        DOE,
    output logic [1:0]  DSACK_N,
    output logic [7:0]  CTRL,
    output logic        KEY_ERR
);

    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES);

    dfb_state_t  state, state_nxt;
    logic [2:0]  wcnt, wcnt_nxt;
    logic        ack_go;
    logic        as_s, ds_s, sel;
    logic [3:0]  acc_addr;
    logic        acc_rd;
    logic [2:0]  idx;
    logic        wr_even;
    logic [7:0]  rd_data;
    logic [15:0] tick;
    logic [7:0]  tick_latch;
    logic [7:0]  scratch;
    logic [7:0]  ctrl_q;
    logic        key_err_q;
    logic        key_armed;
    logic        unused_bits;

    assign unused_bits = ^{A[15:4], STAT_IN[7:6]};

    dfb_sync2 u_sync_as (.CLKOSC(CLKOSC), .RST(RST), .d(AS), .q(as_s));
    dfb_sync2 u_sync_ds (.CLKOSC(CLKOSC), .RST(RST), .d(DS), .q(ds_s));

    assign sel     = ~as_s & (A[31:16] == BASE);
    assign idx     = acc_addr[3:1];
    assign wr_even = ack_go & ~acc_rd & ~acc_addr[0];
    assign CTRL    = ctrl_q;
    assign KEY_ERR = key_err_q;

    // State and wait-counter register
    always_ff @(posedge CLKOSC or negedge RST) begin
        if (!RST) begin
            state <= ST_IDLE;
            wcnt  <= 3'd0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    // Next-state logic; ack_go marks the edge that acknowledges and commits
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        ack_go    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sel) begin
                    state_nxt = ST_WAIT;
                    wcnt_nxt  = WAIT_LOAD;
                end
            end
            ST_WAIT: begin
                if (as_s) begin
                    state_nxt = ST_IDLE;
                end else if (wcnt == 3'd0) begin
                    if (!ds_s) begin
                        state_nxt = ST_ACK;
                        ack_go    = 1'b1;
                    end
                end else begin
                    wcnt_nxt = wcnt - 3'd1;
                end
            end
            ST_ACK:  state_nxt = ST_HOLD;
            ST_HOLD: if (as_s) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Capture address and direction when the cycle is claimed
    always_ff @(posedge CLKOSC or negedge RST) begin
        if (!RST) begin
            acc_addr <= 4'd0;
            acc_rd   <= 1'b1;
        end else if (state == ST_IDLE && sel) begin
            acc_addr <= A[3:0];
            acc_rd   <= XRW;
        end
    end

    // Read data selection; odd bytes float high
    always_comb begin
        rd_data = 8'h00;
        case (idx)
            REG_CTRL:    rd_data = ctrl_q;
            REG_STATUS:  rd_data = {key_err_q, key_armed, STAT_IN[5:0]};
            REG_SCRATCH: rd_data = scratch;
            REG_REV:     rd_data = REVISION;
            REG_TICK_LO: rd_data = tick[7:0];
            REG_TICK_HI: rd_data = tick_latch;
            default:     rd_data = 8'h00;
        endcase
        if (acc_addr[0]) rd_data = 8'hFF;
    end

    // Bus-facing outputs: assert on the acknowledge edge, release when AS rises
    always_ff @(posedge CLKOSC or negedge RST) begin
        if (!RST) begin
            DSACK_N <= 2'b11;
            DOE     <= 1'b0;
            DOUT    <= 8'hFF;
        end else if (ack_go) begin
            DSACK_N <= 2'b01;
            DOE     <= acc_rd;
            if (acc_rd) DOUT <= rd_data;
        end else if (state == ST_HOLD && as_s) begin
            DSACK_N <= 2'b11;
            DOE     <= 1'b0;
        end
    end

    // Register writes and key protection; any completed non-KEY access disarms
    always_ff @(posedge CLKOSC or negedge RST) begin
        if (!RST) begin
            ctrl_q    <= 8'h00;
            scratch   <= 8'h00;
            key_err_q <= 1'b0;
            key_armed <= 1'b0;
        end else if (ack_go) begin
            key_armed <= (wr_even && idx == REG_KEY) ? (DIN == UNLOCK_KEY) : 1'b0;
            if (wr_even && idx == REG_CTRL && key_armed) ctrl_q <= DIN;
            if (wr_even && idx == REG_SCRATCH) scratch <= DIN;
            // A failed CTRL write takes priority over a clear
            if (wr_even && idx == REG_CTRL && !key_armed)
                key_err_q <= 1'b1;
            else if (wr_even && idx == REG_KERRCLR)
                key_err_q <= 1'b0;
        end
    end

    // Free-running tick counter; high byte frozen by a TICK_LO read
    always_ff @(posedge CLKOSC or negedge RST) begin
        if (!RST) begin
            tick       <= 16'h0000;
            tick_latch <= 8'h00;
        end else begin
            tick <= tick + 16'h0001;
            if (ack_go && acc_rd && !acc_addr[0] && idx == REG_TICK_LO)
                tick_latch <= tick[15:8];
        end
    end

endmodule

// File: tb/tb_dfb_reg_port.sv
// Bench for dfb_reg_port: directed register-map cases plus random accesses
// against a behavioural register model.
module tb_dfb_reg_port;

    localparam int unsigned WS = 2;

    logic        CLKOSC = 1'b0;
    logic        RST;
    logic [31:0] A;
    logic        AS, DS, XRW;
    logic [7:0]  DIN, STAT_IN;
    logic [7:0]  DOUT;
    logic        DOE;
    logic [1:0]  DSACK_N;
    logic [7:0]  CTRL;
    logic        KEY_ERR;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    logic [7:0]  m_ctrl, m_scr, m_latch;
    logic        m_kerr, m_armed;
    logic [15:0] m_tick;

    dfb_reg_port #(
        .BASE(16'h00F1), .WAIT_STATES(WS), .REVISION(8'h15), .UNLOCK_KEY(8'hA5)
    ) dut (
        .CLKOSC(CLKOSC), .RST(RST), .A(A), .AS(AS), .DS(DS), .XRW(XRW),
        .DIN(DIN), .STAT_IN(STAT_IN), .DOUT(DOUT), .DOE(DOE),
        .DSACK_N(DSACK_N), .CTRL(CTRL), .KEY_ERR(KEY_ERR)
    );

    always #5 CLKOSC = ~CLKOSC;

    // Reference cycle count: counts every clock out of reset
    always @(posedge CLKOSC or negedge RST) begin
        if (!RST) m_tick <= 16'h0000;
        else      m_tick <= m_tick + 16'h0001;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLKOSC);
        #1;
    endtask

    task automatic model_reset();
        m_ctrl  = 8'h00;
        m_scr   = 8'h00;
        m_latch = 8'h00;
        m_kerr  = 1'b0;
        m_armed = 1'b0;
    endtask

    function automatic logic [7:0] exp_read(input logic [3:0] a, input logic [15:0] t);
        if (a[0]) return 8'hFF;
        case (a[3:1])
            3'd0: return m_ctrl;
            3'd1: return {m_kerr, m_armed, STAT_IN[5:0]};
            3'd2: return m_scr;
            3'd3: return 8'h15;
            3'd5: return t[7:0];
            3'd6: return m_latch;
            default: return 8'h00;
        endcase
    endfunction

    // One bus cycle, started #1 after a clock edge
    task automatic access(input logic [31:0] addr, input logic rd, input logic [7:0] wd,
                          input logic exp_ack, output logic [7:0] rdat);
        int n;
        logic [15:0] t;
        A = addr; XRW = rd; DIN = wd; AS = 1'b0; DS = 1'b0;
        rdat = 8'hxx;
        if (exp_ack) begin
            n = 0;
            while (DSACK_N !== 2'b01 && n < 30) begin step(); n++; end
            chk("ack_latency", n, 4 + WS);
            t = m_tick - 16'h0001;
            rdat = DOUT;
            chk("doe_on", DOE, rd);
            if (rd) chk("rdata", DOUT, exp_read(addr[3:0], t));
            if (!rd && !addr[0] && addr[3:1] == 3'd4) begin
                m_armed = (wd == 8'hA5);
            end else begin
                if (!rd && !addr[0]) begin
                    case (addr[3:1])
                        3'd0: if (m_armed) m_ctrl = wd; else m_kerr = 1'b1;
                        3'd2: m_scr = wd;
                        3'd7: m_kerr = 1'b0;
                        default: ;
                    endcase
                end
                if (rd && !addr[0] && addr[3:1] == 3'd5) m_latch = t[15:8];
                m_armed = 1'b0;
            end
            AS = 1'b1; DS = 1'b1;
            n = 0;
            while (DSACK_N !== 2'b11 && n < 30) begin step(); n++; end
            chk("rel_latency", n, 3);
            chk("doe_off", DOE, 0);
            chk("ctrl", CTRL, m_ctrl);
            chk("key_err", KEY_ERR, m_kerr);
        end else begin
            repeat (10) step();
            chk("no_ack", DSACK_N, 2'b11);
            AS = 1'b1; DS = 1'b1;
            repeat (3) step();
        end
        step();
    endtask

    initial begin
        logic [7:0]  r;
        logic [31:0] addr;
        logic [2:0]  idx;
        logic        rd;
        logic [7:0]  wd;
        int          n, sel;

        RST = 1'b0; AS = 1'b1; DS = 1'b1; A = 32'h0; XRW = 1'b1;
        DIN = 8'h00; STAT_IN = 8'h00;
        model_reset();
        repeat (3) step();
        chk("rst_dsack", DSACK_N, 2'b11);
        chk("rst_doe", DOE, 0);
        chk("rst_dout", DOUT, 8'hFF);
        chk("rst_ctrl", CTRL, 8'h00);
        chk("rst_kerr", KEY_ERR, 0);
        RST = 1'b1;
        step();

        // REV read, then CTRL without key
        access(32'h00F10006, 1'b1, 8'h00, 1'b1, r);
        chk("rev", r, 8'h15);
        access(32'h00F10000, 1'b0, 8'h07, 1'b1, r);
        chk("ctrl_nokey", CTRL, 8'h00);
        chk("kerr_set", KEY_ERR, 1);

        // KEY then CTRL
        access(32'h00F10008, 1'b0, 8'hA5, 1'b1, r);
        STAT_IN = 8'h2A;
        access(32'h00F10002, 1'b1, 8'h00, 1'b1, r);
        chk("status_armed", r, 8'hEA);
        access(32'h00F10008, 1'b0, 8'hA5, 1'b1, r);
        access(32'h00F10000, 1'b0, 8'h07, 1'b1, r);
        chk("ctrl_key", CTRL, 8'h07);
        access(32'h00F10002, 1'b1, 8'h00, 1'b1, r);
        chk("armed_clr", r[6], 0);

        // KEY, SCRATCH, CTRL: the scratch access disarms
        access(32'h00F1000E, 1'b0, 8'h55, 1'b1, r);
        chk("kerr_clr0", KEY_ERR, 0);
        access(32'h00F10008, 1'b0, 8'hA5, 1'b1, r);
        access(32'h00F10004, 1'b0, 8'h3C, 1'b1, r);
        access(32'h00F10000, 1'b0, 8'h01, 1'b1, r);
        chk("ctrl_kept", CTRL, 8'h07);
        chk("kerr_again", KEY_ERR, 1);
        access(32'h00F10004, 1'b1, 8'h00, 1'b1, r);
        chk("scratch", r, 8'h3C);
        access(32'h00F1000E, 1'b0, 8'h00, 1'b1, r);
        chk("kerr_clr", KEY_ERR, 0);

        // Odd byte and foreign address
        access(32'h00F10001, 1'b1, 8'h00, 1'b1, r);
        chk("odd_read", r, 8'hFF);
        access(32'h00F20000, 1'b1, 8'h00, 1'b0, r);

        // AS withdrawn during WAIT: no ack, write not committed
        A = 32'h00F10004; XRW = 1'b0; DIN = 8'h99; AS = 1'b0; DS = 1'b1;
        repeat (5) step();
        chk("abort_wait", DSACK_N, 2'b11);
        AS = 1'b1;
        repeat (6) step();
        chk("abort_rel", DSACK_N, 2'b11);
        access(32'h00F10004, 1'b1, 8'h00, 1'b1, r);
        chk("abort_nocommit", r, 8'h3C);

        // Random accesses against the model
        for (int i = 0; i < 60; i++) begin
            sel  = $urandom_range(0, 99);
            idx  = 3'($urandom_range(0, 7));
            rd   = 1'($urandom_range(0, 1));
            wd   = ($urandom_range(0, 2) == 0) ? 8'hA5 : 8'($urandom);
            addr = {16'h00F1, 12'($urandom), idx, 1'b0};
            if (sel < 10) addr[0] = 1'b1;
            STAT_IN = 8'($urandom);
            if (sel >= 95) begin
                addr[31:16] = 16'h00F0 + 16'($urandom_range(2, 9));
                access(addr, rd, wd, 1'b0, r);
            end else begin
                access(addr, rd, wd, 1'b1, r);
            end
        end

        // Coherent tick read: TICK_LO sampled at 12FF
        n = 0;
        while (m_tick != 16'h12FA && n < 8000) begin step(); n++; end
        if (n >= 8000) begin
            total++; bad++;
            $display("FAIL tick_wait timeout got=%0h exp=12fa", m_tick);
        end
        access(32'h00F1000A, 1'b1, 8'h00, 1'b1, r);
        chk("tick_lo", r, 8'hFF);
        repeat (10) step();
        access(32'h00F1000C, 1'b1, 8'h00, 1'b1, r);
        chk("tick_hi", r, 8'h12);

        // Reset while in HOLD
        access(32'h00F10008, 1'b0, 8'hA5, 1'b1, r);
        access(32'h00F10000, 1'b0, 8'h0F, 1'b1, r);
        chk("ctrl_pre_rst", CTRL, 8'h0F);
        A = 32'h00F10006; XRW = 1'b1; AS = 1'b0; DS = 1'b0;
        n = 0;
        while (DSACK_N !== 2'b01 && n < 30) begin step(); n++; end
        step();
        chk("hold_dsack", DSACK_N, 2'b01);
        chk("hold_doe", DOE, 1);
        #2 RST = 1'b0;
        #1;
        chk("arst_dsack", DSACK_N, 2'b11);
        chk("arst_doe", DOE, 0);
        chk("arst_ctrl", CTRL, 8'h00);
        AS = 1'b1; DS = 1'b1;
        model_reset();
        repeat (3) step();
        RST = 1'b1;
        step();
        access(32'h00F10004, 1'b1, 8'h00, 1'b1, r);
        chk("post_rst_scratch", r, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dfb_reg_port.md
Name: dfb_reg_port

Overview:
- Bus responder for the accelerator's own 68030-visible register window at $00F1xxxx.
- Implements the registers behind that decode: control bits, a read-only status byte, scratch, a revision ID, a key-protected control write, and a latched 16-bit tick counter.
- Presents a 16-bit port: DSACK[1] is asserted, DSACK[0] is not.
- Sits beside the top-level DSACK merge; its DSACK_N is ANDed into the board DSACK, and its CTRL outputs feed the fast/altram/flash enables.

Parameters:
- BASE, 16'h00F1, value of A[31:16] that selects the window.
- WAIT_STATES, 2, CLKOSC cycles inserted between synchronised AS and DSACK assertion (0..7).
- REVISION, 8'h15, value returned by the REV register.
- UNLOCK_KEY, 8'hA5, byte that must be written to KEY immediately before a CTRL write.

Ports:
- CLKOSC, input, 1, sole clock (oscillator domain).
- RST, input, 1, asynchronous active-low reset.
- A, input, 32, CPU address.
- AS, input, 1, CPU address strobe, active low, asynchronous to CLKOSC.
- DS, input, 1, CPU data strobe, active low, asynchronous.
- XRW, input, 1, 1 = read, 0 = write.
- DIN, input, 8, write data (lane steering is done externally).
- STAT_IN, input, 8, live status bits sampled into STATUS.
- DOUT, output, 8, read data.
- DOE, output, 1, high = drive DOUT onto the bus.
- DSACK_N, output, 2, active-low acknowledge; bit 0 is always 1.
- CTRL, output, 8, control register contents.
- KEY_ERR, output, 1, sticky flag: a CTRL write was attempted without the key.

Behaviour:
- Reset values (while RST low, and asynchronously on entry to reset):
  - DSACK_N = 2'b11, DOE = 0, DOUT = 8'hFF.
  - CTRL = 8'h00, KEY_ERR = 0, scratch = 8'h00.
  - Tick counter = 0, latch = 0, key_armed = 0, FSM = IDLE.
- Synchronisation: AS and DS each pass through two CLKOSC flops; as_s and ds_s are the synchronised versions.
- Select: sel = ~as_s & (A[31:16] == BASE). Address and XRW are sampled into a register on the IDLE->WAIT transition.
- Register map, index = A[3:1], even bytes only:
  - 0 CTRL: read/write, key-protected.
  - 1 STATUS: read-only, {KEY_ERR, key_armed, STAT_IN[5:0]}.
  - 2 SCRATCH: read/write.
  - 3 REV: read-only.
  - 4 KEY: write-only; reads 8'h00.
  - 5 TICK_LO: read returns the counter's low byte and latches the high byte.
  - 6 TICK_HI: returns the latched high byte.
  - 7 KEY_ERR clear: a write of any value clears KEY_ERR; reads 8'h00.
- Odd byte (A[0] = 1): reads return 8'hFF; writes are ignored. The cycle is still acknowledged.
- FSM states: IDLE, WAIT, ACK, HOLD.
  - IDLE -> WAIT when sel; load the wait counter with WAIT_STATES.
  - WAIT: decrement the counter each cycle. Go to ACK when it is 0 and ds_s is low. If as_s goes high, return to IDLE with no acknowledge.
  - ACK, one cycle, and then unconditionally to HOLD:
    - On a read: drive DOUT and DOE.
    - On a write: commit DIN, then assert DSACK_N = 2'b01.
  - HOLD: keep DSACK_N and DOE until as_s is high, then return to IDLE. DSACK_N = 2'b11 and DOE = 0 take effect in that same transition cycle.
- Latency: DSACK falls 2 (sync) + 1 + WAIT_STATES + 1 CLKOSC edges after AS falls, so 6 with the default. Release occurs 3 edges after AS rises.
- Key protection:
  - A write of UNLOCK_KEY to KEY sets key_armed. A write of any other value to KEY clears it.
  - A CTRL write with key_armed set updates CTRL and clears key_armed.
  - A CTRL write without key_armed leaves CTRL unchanged and sets KEY_ERR.
  - Any completed access other than a KEY write clears key_armed.
- Tick counter:
  - 16 bits, increments every CLKOSC cycle and wraps from FFFF to 0000.
  - The latch updates only in the ACK cycle of a TICK_LO read. The TICK_LO and TICK_HI reads therefore return one coherent sample.
  - If a KEY_ERR set and a KEY_ERR clear fall in the same cycle, set wins.
- Reset mid-cycle: the FSM returns to IDLE and DSACK_N is released immediately (asynchronously). A write in flight that has not reached ACK is not committed.

Decomposition:
- Shared package dfb_pkg holds:
  - register index constants (REG_CTRL=0 .. REG_KERRCLR=7);
  - the FSM state encoding;
  - CTRL bit positions: bit0 fast_en, bit1 altram_en, bit2 flash_en, bit3 boost_lock.
- One natural sub-module, dfb_sync2: a two-flop synchroniser with reset to 1. It is instantiated for AS and for DS.

Test Plan:
- Read REV at $00F10006 with defaults -> DSACK_N = 2'b01 six edges after AS falls; DOUT = 8'h15; DSACK_N returns to 2'b11 three edges after AS rises.
- Write 8'h07 to CTRL without the key -> CTRL stays 8'h00 and KEY_ERR = 1. Write 8'hA5 to KEY, then 8'h07 to CTRL -> CTRL = 8'h07 and key_armed = 0.
- KEY, then a SCRATCH write of 8'h3C, then CTRL 8'h01 -> CTRL unchanged, KEY_ERR = 1, SCRATCH reads 8'h3C. A write to index 7 -> KEY_ERR = 0.
- Force the tick counter to 16'h12FF, read TICK_LO, wait 10 cycles, then read TICK_HI -> the TICK_HI result is 8'h12 (the latched value), not 8'h13.
- Odd-byte read at $00F10001 -> DOUT = 8'hFF with an acknowledge. An address of $00F20000 -> DSACK_N stays 2'b11.
- Assert RST low while in HOLD -> DSACK_N = 2'b11 and DOE = 0 without waiting for a clock edge; CTRL = 8'h00. AS rising during WAIT -> no acknowledge and the FSM returns to IDLE.
